// File: rtl/uart_avalon_poller.sv
// rtl/uart_avalon_poller.sv - Avalon-MM master that polls a UART and buffers RX bytes in a FWFT FIFO
//
// Optional feature macro: UART_POLLER_TX_EN (when defined, pending tx bytes are written to TXDATA).
//
// Ports:
//   clock_sink_clk / reset_sink_reset   clock, synchronous active-low reset
//   avalon_master_*                     Avalon-MM master (one transaction outstanding)
//   rx_data / rx_valid / rx_ready       FWFT stream of received bytes
//   tx_data / tx_valid / tx_ready       byte to transmit; tx_ready pulses on write acceptance
//   fifo_level / rx_count               FIFO occupancy, wrapping count of received bytes
//   overflow / clear_overflow           sticky UART overrun flag and its clear
`timescale 1ns/1ps
module uart_avalon_poller #(
  parameter int                DATA_W      = 16,
  parameter int                ADDR_W      = 5,
  parameter logic [ADDR_W-1:0] RXDATA_ADDR = ADDR_W'('h00),
  parameter logic [ADDR_W-1:0] TXDATA_ADDR = ADDR_W'('h04),
  parameter logic [ADDR_W-1:0] STATUS_ADDR = ADDR_W'('h08),
  parameter int                RRDY_BIT    = 7,
  parameter int                TRDY_BIT    = 6,
  parameter int                ROE_BIT     = 3,
  parameter int                FIFO_DEPTH  = 8,
  parameter int                POLL_GAP    = 0
) (
  input  logic                       clock_sink_clk,
  input  logic                       reset_sink_reset,
  output logic                       avalon_master_read,
  output logic                       avalon_master_write,
  output logic [ADDR_W-1:0]          avalon_master_address,
  output logic [DATA_W-1:0]          avalon_master_writedata,
  input  logic [DATA_W-1:0]          avalon_master_readdata,
  input  logic                       avalon_master_readdatavalid,
  input  logic                       avalon_master_waitrequest,
  output logic [7:0]                 rx_data,
  output logic                       rx_valid,
  input  logic                       rx_ready,
  input  logic [7:0]                 tx_data,
  input  logic                       tx_valid,
  output logic                       tx_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [15:0]                rx_count,
  output logic                       overflow,
  input  logic                       clear_overflow
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LVL_W = AW + 1;
  localparam int GAP_W = (POLL_GAP > 0) ? $clog2(POLL_GAP + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(POLL_GAP);

  typedef enum logic [2:0] {
    S_POLL      = 3'd0,
    S_STAT_WAIT = 3'd1,
    S_RX_RD     = 3'd2,
    S_RX_WAIT   = 3'd3,
    S_GAP       = 3'd4
`ifdef UART_POLLER_TX_EN
    ,S_TX_WR    = 3'd5
`endif
  } state_t;

  state_t             state;
  logic               rd_q;
  logic               wr_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [GAP_W-1:0]   gap_cnt;
  logic               ovf_q;

  logic [7:0]         mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [LVL_W-1:0]   level;
  logic [15:0]        cnt_q;

  logic fifo_full;
  logic fifo_empty;
  logic stat_sample;
  logic st_rrdy;
  logic st_roe;
  logic push;
  logic pop;
  logic unused_inputs;

  assign fifo_full   = (level == LVL_W'(FIFO_DEPTH));
  assign fifo_empty  = (level == '0);
  assign stat_sample = (state == S_STAT_WAIT) && avalon_master_readdatavalid;
  assign st_rrdy     = avalon_master_readdata[RRDY_BIT];
  assign st_roe      = avalon_master_readdata[ROE_BIT];
  // The full check is redundant with the RRDY gating in S_STAT_WAIT but keeps
  // the FIFO safe on its own.
  assign push        = (state == S_RX_WAIT) && avalon_master_readdatavalid && !fifo_full;
  assign pop         = !fifo_empty && rx_ready;
  assign unused_inputs = ^{avalon_master_readdata, tx_data, tx_valid};

  assign avalon_master_read      = rd_q;
  assign avalon_master_write     = wr_q;
  assign avalon_master_address   = addr_q;
  assign avalon_master_writedata = wdata_q;
  assign rx_data                 = mem[rd_ptr];
  assign rx_valid                = !fifo_empty;
  assign fifo_level              = level;
  assign rx_count                = cnt_q;
  assign overflow                = ovf_q;

`ifdef UART_POLLER_TX_EN
  // Accepted on the same cycle the write strobe meets a low waitrequest.
  assign tx_ready = wr_q && !avalon_master_waitrequest;
`else
  assign wr_q     = 1'b0;
  assign wdata_q  = '0;
  assign tx_ready = 1'b0;
`endif

  // Transaction sequencer. Each state that issues a transaction has its strobe
  // raised on the transition into it, so strobes and address are registered.
  always_ff @(posedge clock_sink_clk) begin
    if (!reset_sink_reset) begin
      state   <= S_POLL;
      rd_q    <= 1'b0;
      addr_q  <= '0;
      gap_cnt <= '0;
`ifdef UART_POLLER_TX_EN
      wr_q    <= 1'b0;
      wdata_q <= '0;
`endif
    end else begin
      case (state)
        S_POLL: begin
          // Only after reset does S_POLL start with the strobe low.
          if (!rd_q) begin
            rd_q   <= 1'b1;
            addr_q <= STATUS_ADDR;
          end else if (!avalon_master_waitrequest) begin
            rd_q  <= 1'b0;
            state <= S_STAT_WAIT;
          end
        end
        S_STAT_WAIT: begin
          if (avalon_master_readdatavalid) begin
            if (st_rrdy && !fifo_full) begin
              state  <= S_RX_RD;
              rd_q   <= 1'b1;
              addr_q <= RXDATA_ADDR;
            end
`ifdef UART_POLLER_TX_EN
            else if (avalon_master_readdata[TRDY_BIT] && tx_valid) begin
              state   <= S_TX_WR;
              wr_q    <= 1'b1;
              addr_q  <= TXDATA_ADDR;
              wdata_q <= DATA_W'(tx_data);
            end
`endif
            else begin
              state   <= S_GAP;
              gap_cnt <= '0;
            end
          end
        end
        S_RX_RD: begin
          if (!avalon_master_waitrequest) begin
            rd_q  <= 1'b0;
            state <= S_RX_WAIT;
          end
        end
        S_RX_WAIT: begin
          if (avalon_master_readdatavalid) begin
            state   <= S_GAP;
            gap_cnt <= '0;
          end
        end
`ifdef UART_POLLER_TX_EN
        S_TX_WR: begin
          if (!avalon_master_waitrequest) begin
            wr_q    <= 1'b0;
            state   <= S_GAP;
            gap_cnt <= '0;
          end
        end
`endif
        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state  <= S_POLL;
            rd_q   <= 1'b1;
            addr_q <= STATUS_ADDR;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        default: begin
          state <= S_POLL;
          rd_q  <= 1'b0;
        end
      endcase
    end
  end

  // Sticky overrun flag; a new overrun sample beats a simultaneous clear.
  always_ff @(posedge clock_sink_clk) begin
    if (!reset_sink_reset) begin
      ovf_q <= 1'b0;
    end else if (stat_sample && st_roe) begin
      ovf_q <= 1'b1;
    end else if (clear_overflow) begin
      ovf_q <= 1'b0;
    end
  end

  // FIFO pointers, occupancy and received-byte counter.
  always_ff @(posedge clock_sink_clk) begin
    if (!reset_sink_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        cnt_q  <= cnt_q + 16'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clock_sink_clk) begin
    if (push) begin
      mem[wr_ptr] <= avalon_master_readdata[7:0];
    end
  end

endmodule

// File: doc/uart_avalon_poller.md
Name: uart_avalon_poller

Overview:
- Parametrised successor to the cube's UART front end.
- Acts as an Avalon-MM master. It polls the UART status register, reads received bytes when RRDY is set, and buffers them in an internal first-word-fall-through (FWFT) FIFO.
- Presents the buffered bytes to LED_cube_driver through a valid/ready stream.
- Optionally transmits bytes back out through the UART TXDATA register.

Parameters:
- DATA_W, 16, Avalon data width (min 8; byte lives in [7:0])
- ADDR_W, 5, Avalon address width
- RXDATA_ADDR, 5'h00, UART rxdata register address
- TXDATA_ADDR, 5'h04, UART txdata register address
- STATUS_ADDR, 5'h08, UART status register address
- RRDY_BIT, 7, status bit index for receive-ready
- TRDY_BIT, 6, status bit index for transmit-ready
- ROE_BIT, 3, status bit index for receive-overrun error
- FIFO_DEPTH, 8, RX FIFO entries; must be a power of 2, >=2
- POLL_GAP, 0, idle cycles inserted between transactions

Ports:
- clock_sink_clk in 1: sole clock, rising edge
- reset_sink_reset in 1: synchronous reset, active-low
- avalon_master_read out 1: read strobe
- avalon_master_write out 1: write strobe
- avalon_master_address out ADDR_W: register address
- avalon_master_writedata out DATA_W: write data
- avalon_master_readdata in DATA_W: read data
- avalon_master_readdatavalid in 1: read data valid
- avalon_master_waitrequest in 1: slave stall
- rx_data out 8: FIFO head byte
- rx_valid out 1: FIFO not empty
- rx_ready in 1: consumer pop
- tx_data in 8: byte to send
- tx_valid in 1: tx byte pending
- tx_ready out 1: tx byte accepted (1-cycle pulse)
- fifo_level out $clog2(FIFO_DEPTH)+1: current FIFO occupancy
- rx_count out 16: bytes received, wraps from 0xFFFF to 0
- overflow out 1: sticky UART overrun flag
- clear_overflow in 1: clears overflow

Behaviour:
- Reset (reset_sink_reset==0 at a clock edge):
  - FSM goes to S_POLL.
  - read, write, tx_ready, overflow, rx_valid are 0; address and writedata are 0.
  - FIFO is emptied, fifo_level=0, rx_count=0.
  - Reset mid-transaction abandons the transaction: strobes drop on that edge, and a readdatavalid arriving later is ignored.
- Avalon rules:
  - One transaction outstanding at most.
  - read/write, address and writedata are held stable while waitrequest=1.
  - A transaction is accepted on the first cycle where the strobe is 1 and waitrequest=0.
  - readdatavalid outside S_STAT_WAIT and S_RX_WAIT is ignored.
- FSM:
  - S_POLL: read=1, address=STATUS_ADDR. On acceptance go to S_STAT_WAIT.
  - S_STAT_WAIT: on readdatavalid, sample the status word:
    - If ROE set, set overflow.
    - If RRDY set and FIFO not full, go to S_RX_RD.
    - Else, if TX is enabled, TRDY is set and tx_valid=1, go to S_TX_WR.
    - Else go to S_GAP.
    - RX has priority over TX.
  - S_RX_RD: read=1, address=RXDATA_ADDR. On acceptance go to S_RX_WAIT.
  - S_RX_WAIT: on readdatavalid, push readdata[7:0] into the FIFO, increment rx_count, go to S_GAP.
  - S_TX_WR: write=1, address=TXDATA_ADDR, writedata={zeros, tx_data}. On acceptance, tx_ready=1 for that cycle, then go to S_GAP.
  - S_GAP: wait POLL_GAP cycles, then go to S_POLL. With POLL_GAP=0 it passes straight through in 1 cycle.
- FIFO:
  - FWFT: rx_data is valid whenever rx_valid=1.
  - A pop occurs when rx_valid && rx_ready.
  - RRDY seen with the FIFO full: no RX read is issued, so the byte stays in the UART (backpressure) and polling continues.
  - Simultaneous push and pop: fifo_level unchanged.
  - Pop while empty: ignored.
- Latency: a pushed byte appears on rx_data with rx_valid=1 on the cycle after the rx readdatavalid.
- overflow:
  - Set on an ROE sample; cleared by clear_overflow=1.
  - If set and clear occur in the same cycle, set wins.

Optional Feature:
- Macro: UART_POLLER_TX_EN.
- Defined: TX path exactly as described in Behaviour.
- Undefined:
  - S_TX_WR is absent.
  - avalon_master_write=0, writedata=0, tx_ready=0.
  - TRDY and tx_data/tx_valid are ignored.

Test Plan:
- Reset, then status readdata=16'h0000 with waitrequest=0 and 1-cycle readdatavalid latency → repeated reads at address 5'h08 only, rx_valid=0, rx_count=0.
- Status=16'h0080, then rxdata=16'h00A5 → one read at 5'h00; next cycle rx_data=8'hA5, rx_valid=1, fifo_level=1, rx_count=1.
- rx_ready=0 with 9 RRDY polls, FIFO_DEPTH=8 → exactly 8 RX reads and fifo_level=8; after that, only status reads. Pop one byte → a 9th RX read follows.
- waitrequest held 3 cycles during an RX read → address 5'h00 and read=1 stable for all 4 cycles; exactly one push.
- Status=16'h0008 → overflow=1, stays 1. Raise clear_overflow → overflow=0. Raise clear_overflow on the same cycle as a new ROE sample → overflow=1.
- UART_POLLER_TX_EN defined, tx_valid=1, tx_data=8'h3C, status=16'h0040 → write at 5'h04 with writedata=16'h003C and a one-cycle tx_ready pulse. Status=16'h00C0 → RX read is issued first.
